// File: rtl/bcd_timer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bcd_timer_pkg
// Description : Shared types and helpers for the BCD interval timer: FSM
//               state encoding, BCD digit/stage types and preset clamping.
// Revision    : 1.0 - initial release
// ============================================================================
package bcd_timer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    typedef logic [3:0] digit_t;
    typedef logic [7:0] stage_t;

    // Binary value (0..99) to a two-digit BCD stage; used on constants only.
    function automatic stage_t to_bcd(input int unsigned v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    // Force a preset stage into the legal range: digits saturate at 9, then
    // the stage saturates at mod-1. With legal digits a plain unsigned
    // compare of the BCD byte orders the same way as the decimal value.
    function automatic stage_t bcd_clamp(input stage_t s, input int unsigned mod);
        digit_t tens;
        digit_t ones;
        stage_t max_bcd;
        tens    = (s[7:4] > 4'd9) ? 4'd9 : s[7:4];
        ones    = (s[3:0] > 4'd9) ? 4'd9 : s[3:0];
        max_bcd = to_bcd(mod - 1);
        if ({tens, ones} > max_bcd) begin
            return max_bcd;
        end
        return {tens, ones};
    endfunction

endpackage : bcd_timer_pkg
`default_nettype wire

// File: rtl/bcd_stage.sv
`default_nettype none
// ============================================================================
// Module      : bcd_stage
// Description : One two-digit BCD counter stage of modulus MOD, counting up
//               or down when enabled, with a synchronous parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_stage
    import bcd_timer_pkg::*;
#(
    parameter int unsigned MOD = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       down,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry_out,
    output logic       borrow_out
);

    localparam stage_t C_MAX_BCD = to_bcd(MOD - 1);

    stage_t r_value;
    stage_t w_next;

    // Next value one step up or down, wrapping at the stage modulus.
    always_comb begin
        w_next = r_value;
        if (down) begin
            if (r_value == 8'h00) begin
                w_next = C_MAX_BCD;
            end else if (r_value[3:0] == 4'd0) begin
                w_next = {r_value[7:4] - 4'd1, 4'd9};
            end else begin
                w_next = {r_value[7:4], r_value[3:0] - 4'd1};
            end
        end else begin
            if (r_value == C_MAX_BCD) begin
                w_next = 8'h00;
            end else if (r_value[3:0] == 4'd9) begin
                w_next = {r_value[7:4] + 4'd1, 4'd0};
            end else begin
                w_next = {r_value[7:4], r_value[3:0] + 4'd1};
            end
        end
    end

    // Stage register: load has priority over counting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_value <= 8'h00;
        end else if (load) begin
            r_value <= load_val;
        end else if (en) begin
            r_value <= w_next;
        end
    end

    assign value      = r_value;
    assign carry_out  = (r_value == C_MAX_BCD);
    assign borrow_out = (r_value == 8'h00);

endmodule : bcd_stage
`default_nettype wire

// File: rtl/bcd_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_interval_timer
// Description : Multi-stage BCD stopwatch / interval timer with preset load,
//               start/stop, expiry detection and optional auto-reload.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_interval_timer
    import bcd_timer_pkg::*;
#(
    parameter int unsigned STAGES  = 2,
    parameter int unsigned LOW_MOD = 60,
    parameter int unsigned TOP_MOD = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  load,
    input  logic [8*STAGES-1:0]   preset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  down,
    input  logic                  auto_reload,
    output logic [8*STAGES-1:0]   count,
    output logic                  running,
    output logic                  expired,
    output logic                  done,
    output logic                  wrap
);

    state_t                r_state;
    logic                  r_running;
    logic                  r_expired;
    logic                  r_done;
    logic                  r_wrap;
    logic [8*STAGES-1:0]   r_reload;

    logic [8*STAGES-1:0]   w_value;
    logic [8*STAGES-1:0]   w_preset_clamp;
    logic [8*STAGES-1:0]   w_load_val;
    logic [STAGES-1:0]     w_carry;
    logic [STAGES-1:0]     w_borrow;
    logic [STAGES-1:0]     w_en;
    logic                  w_is_zero;
    logic                  w_is_one;
    logic                  w_all_max;
    logic                  w_tick_run;
    logic                  w_reload_now;
    logic                  w_cnt_en;
    logic                  w_stage_load;

    assign w_is_zero = &w_borrow;
    assign w_all_max = &w_carry;
    // Least significant stage is 01 and every higher stage is 00.
    assign w_is_one  = (w_value[7:0] == 8'h01) && (&(w_borrow | STAGES'(1)));

    // A tick only acts in RUN when no higher-priority command is present.
    assign w_tick_run = tick && (r_state == RUN) && !load && !stop;

    // Reload from the reload register: restart from EXPIRED, or auto-reload
    // on the tick that would otherwise bring the count to zero.
    assign w_reload_now = (!load && !stop && start && (r_state == EXPIRED) && (r_reload != '0))
                       || (w_tick_run && down && w_is_one && auto_reload);

    // Counting is suppressed when a down tick finds the count already zero.
    assign w_cnt_en     = w_tick_run && !(down && w_is_zero);
    assign w_stage_load = load || w_reload_now;
    assign w_load_val   = load ? w_preset_clamp : r_reload;

    // Ripple enable: a stage steps when every lower stage wraps this tick.
    always_comb begin
        logic w_chain;
        w_chain = w_cnt_en;
        w_en    = '0;
        for (int k = 0; k < int'(STAGES); k++) begin
            w_en[k] = w_chain;
            w_chain = w_chain && (down ? w_borrow[k] : w_carry[k]);
        end
    end

    generate
        for (genvar k = 0; k < STAGES; k++) begin : g_stage
            localparam int unsigned C_MOD = (k == STAGES - 1) ? TOP_MOD : LOW_MOD;

            assign w_preset_clamp[8*k +: 8] = bcd_clamp(preset[8*k +: 8], C_MOD);

            bcd_stage #(
                .MOD (C_MOD)
            ) u_stage (
                .clk        (clk),
                .reset      (reset),
                .en         (w_en[k]),
                .down       (down),
                .load       (w_stage_load),
                .load_val   (w_load_val[8*k +: 8]),
                .value      (w_value[8*k +: 8]),
                .carry_out  (w_carry[k]),
                .borrow_out (w_borrow[k])
            );
        end
    endgenerate

    // Control FSM with reload register and one-cycle done/wrap pulses.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_expired <= 1'b0;
            r_done    <= 1'b0;
            r_wrap    <= 1'b0;
            r_reload  <= '0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            if (load) begin
                r_reload  <= w_preset_clamp;
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else if (stop) begin
                r_state   <= IDLE;
                r_running <= 1'b0;
                r_expired <= 1'b0;
            end else if (start && (r_state == IDLE) && !(down && w_is_zero)) begin
                r_state   <= RUN;
                r_running <= 1'b1;
                r_expired <= 1'b0;
            end else if (start && (r_state == EXPIRED) && (r_reload != '0)) begin
                r_state   <= RUN;
                r_running <= 1'b1;
                r_expired <= 1'b0;
            end else if (w_tick_run) begin
                if (!down) begin
                    if (w_all_max) begin
                        r_wrap <= 1'b1;
                    end
                end else if (w_is_zero || (w_is_one && !auto_reload)) begin
                    r_done    <= 1'b1;
                    r_state   <= EXPIRED;
                    r_running <= 1'b0;
                    r_expired <= 1'b1;
                end else if (w_is_one) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign count   = w_value;
    assign running = r_running;
    assign expired = r_expired;
    assign done    = r_done;
    assign wrap    = r_wrap;

endmodule : bcd_interval_timer
`default_nettype wire

// File: tb/tb_bcd_interval_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_interval_timer
// Description : Self-checking bench for bcd_interval_timer: an integer-valued
//               reference model compared every cycle, plus directed literals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_interval_timer;

    localparam int STAGES  = 2;
    localparam int LOW_MOD = 60;
    localparam int TOP_MOD = 100;
    localparam int W       = 8 * STAGES;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_EXP  = 2;

    logic         clk;
    logic         reset;
    logic         tick;
    logic         load;
    logic [W-1:0] preset;
    logic         start;
    logic         stop;
    logic         down;
    logic         auto_reload;
    logic [W-1:0] count;
    logic         running;
    logic         expired;
    logic         done;
    logic         wrap;

    int n_checks = 0;
    int n_err    = 0;
    bit check_en = 0;

    // Reference model: count as a plain integer in units of the lowest stage.
    int m_cnt   = 0;
    int m_rel   = 0;
    int m_state = M_IDLE;
    bit m_done  = 0;
    bit m_wrap  = 0;

    bcd_interval_timer #(
        .STAGES  (STAGES),
        .LOW_MOD (LOW_MOD),
        .TOP_MOD (TOP_MOD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .tick        (tick),
        .load        (load),
        .preset      (preset),
        .start       (start),
        .stop        (stop),
        .down        (down),
        .auto_reload (auto_reload),
        .count       (count),
        .running     (running),
        .expired     (expired),
        .done        (done),
        .wrap        (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int stage_mod(input int k);
        return (k == STAGES - 1) ? TOP_MOD : LOW_MOD;
    endfunction

    function automatic int max_val();
        int p = 1;
        for (int k = 0; k < STAGES; k++) p = p * stage_mod(k);
        return p - 1;
    endfunction

    // Preset bytes to integer, saturating digits at 9 and stages at mod-1.
    function automatic int preset_to_int(input logic [W-1:0] p);
        int v = 0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            int t, o, s;
            t = int'(p[8*k+4 +: 4]);
            o = int'(p[8*k +: 4]);
            if (t > 9) t = 9;
            if (o > 9) o = 9;
            s = 10 * t + o;
            if (s >= stage_mod(k)) s = stage_mod(k) - 1;
            v = v * stage_mod(k) + s;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int v);
        logic [W-1:0] r = '0;
        for (int k = 0; k < STAGES; k++) begin
            int s;
            s = v % stage_mod(k);
            v = v / stage_mod(k);
            r[8*k +: 8] = {4'(s / 10), 4'(s % 10)};
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model update on each clock edge from the same sampled inputs.
    always @(posedge clk) begin
        if (!reset) begin
            m_cnt = 0; m_rel = 0; m_state = M_IDLE; m_done = 0; m_wrap = 0;
        end else begin
            m_done = 0;
            m_wrap = 0;
            if (load) begin
                m_cnt   = preset_to_int(preset);
                m_rel   = m_cnt;
                m_state = M_IDLE;
            end else if (stop) begin
                m_state = M_IDLE;
            end else if (start && m_state == M_IDLE && !(down && m_cnt == 0)) begin
                m_state = M_RUN;
            end else if (start && m_state == M_EXP && m_rel != 0) begin
                m_cnt   = m_rel;
                m_state = M_RUN;
            end else if (tick && m_state == M_RUN) begin
                if (!down) begin
                    if (m_cnt == max_val()) begin
                        m_cnt  = 0;
                        m_wrap = 1;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end else if (m_cnt == 0) begin
                    m_state = M_EXP;
                    m_done  = 1;
                end else if (m_cnt == 1) begin
                    m_done = 1;
                    if (auto_reload) begin
                        m_cnt = m_rel;
                    end else begin
                        m_cnt   = 0;
                        m_state = M_EXP;
                    end
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
        end
    end

    // Asynchronous reset clears the model immediately.
    always @(negedge reset) begin
        m_cnt = 0; m_rel = 0; m_state = M_IDLE; m_done = 0; m_wrap = 0;
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            check("cmp_count",   32'(count),   32'(int_to_bcd(m_cnt)));
            check("cmp_running", 32'(running), 32'(m_state == M_RUN));
            check("cmp_expired", 32'(expired), 32'(m_state == M_EXP));
            check("cmp_done",    32'(done),    32'(m_done));
            check("cmp_wrap",    32'(wrap),    32'(m_wrap));
        end
    end

    // One clock of commands, applied at the falling edge and cleared after
    // the rising edge so literal checks see the post-edge outputs.
    task automatic cyc(input logic l, input logic s, input logic p, input logic t);
        @(negedge clk);
        load = l; start = s; stop = p; tick = t;
        @(posedge clk);
        #1;
        load = 0; start = 0; stop = 0; tick = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 0; tick = 0; load = 0; start = 0; stop = 0;
        down = 1; auto_reload = 0; preset = '0;

        // Reset during RUN with count 00:07.
        #2  reset = 1; load = 1; preset = 16'h0007;
        #2  check_en = 1;
        #6  load = 0; start = 1;
        #10 start = 0;
        #1  check("pre_reset_count", 32'(count), 32'h0007);
            check("pre_reset_running", 32'(running), 32'd1);
        #1  reset = 0;
        #1  check("reset_count", 32'(count), 32'h0000);
            check("reset_running", 32'(running), 32'd0);
            check("reset_done", 32'(done), 32'd0);
            check("reset_expired", 32'(expired), 32'd0);
        @(negedge clk);
        reset = 1;
        repeat (3) cyc(0, 0, 0, 1);
        check("hold_after_reset", 32'(count), 32'h0000);

        // Down count with borrow.
        down = 1; preset = 16'h0102;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("borrow_1", 32'(count), 32'h0101);
        cyc(0, 0, 0, 1); check("borrow_2", 32'(count), 32'h0100);
        cyc(0, 0, 0, 1); check("borrow_3", 32'(count), 32'h0059);
        check("borrow_running", 32'(running), 32'd1);
        check("borrow_done", 32'(done), 32'd0);
        cyc(0, 0, 1, 0);

        // Expiry without auto-reload, then restart from the reload register.
        auto_reload = 0; preset = 16'h0002;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("exp_tick1", 32'(count), 32'h0001);
        cyc(0, 0, 0, 1);
        check("exp_count", 32'(count), 32'h0000);
        check("exp_done", 32'(done), 32'd1);
        check("exp_flag", 32'(expired), 32'd1);
        cyc(0, 0, 0, 0); check("exp_done_1cyc", 32'(done), 32'd0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1); check("exp_hold", 32'(count), 32'h0000);
        cyc(0, 1, 0, 0);
        check("exp_restart_count", 32'(count), 32'h0002);
        check("exp_restart_run", 32'(running), 32'd1);
        cyc(0, 0, 1, 0);

        // Auto-reload with period 3.
        auto_reload = 1; preset = 16'h0003;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            cyc(0, 0, 0, 1);
            check("ar_done", 32'(done), 32'((i % 3) == 2));
            check("ar_nonzero", 32'(count == 16'h0000), 32'd0);
            if ((i % 3) == 2) check("ar_reload", 32'(count), 32'h0003);
        end
        cyc(0, 0, 1, 0);
        auto_reload = 0;

        // Up rollover from the maximum value.
        down = 0; preset = 16'h9959;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        check("wrap_count", 32'(count), 32'h0000);
        check("wrap_pulse", 32'(wrap), 32'd1);
        check("wrap_running", 32'(running), 32'd1);
        cyc(0, 0, 0, 0); check("wrap_1cyc", 32'(wrap), 32'd0);
        cyc(0, 0, 0, 1); check("wrap_continue", 32'(count), 32'h0001);
        cyc(0, 0, 1, 0);

        // Preset clamping.
        preset = 16'h7A6C;
        cyc(1, 0, 0, 0); check("clamp_7A6C", 32'(count), 32'h7959);

        // Priorities.
        cyc(0, 1, 0, 0); check("prio_run", 32'(running), 32'd1);
        preset = 16'h0A0B;
        cyc(1, 0, 1, 1);
        check("prio_load_count", 32'(count), 32'h0909);
        check("prio_load_idle", 32'(running), 32'd0);
        cyc(0, 1, 1, 0); check("prio_start_stop", 32'(running), 32'd0);
        down = 1; preset = 16'h0000;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0); check("prio_start_zero_down", 32'(running), 32'd0);

        // Direction change between ticks.
        down = 0;
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1); check("mode_up", 32'(count), 32'h0001);
        down = 1;
        cyc(0, 0, 0, 1);
        check("mode_down_done", 32'(done), 32'd1);
        check("mode_down_exp", 32'(expired), 32'd1);

        // Count already zero in RUN after a direction change.
        down = 0; preset = 16'h0000;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        down = 1;
        cyc(0, 0, 0, 1);
        check("zero_run_done", 32'(done), 32'd1);
        check("zero_run_count", 32'(count), 32'h0000);
        cyc(0, 1, 0, 0); check("zero_reload_ignored", 32'(expired), 32'd1);

        // Reset in the middle of a run clears without pulses.
        down = 1; preset = 16'h0105;
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 1);
        @(negedge clk);
        #2 reset = 0;
        #1 check("midreset_count", 32'(count), 32'h0000);
           check("midreset_done", 32'(done), 32'd0);
           check("midreset_wrap", 32'(wrap), 32'd0);
        @(negedge clk);
        reset = 1;
        cyc(0, 0, 0, 0);
        @(negedge clk);
        check_en = 0;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_bcd_interval_timer
`default_nettype wire

// File: doc/bcd_interval_timer.md
Name: bcd_interval_timer

Overview:
- Parametrised multi-stage BCD timer; successor to the fixed two-digit seconds counter.
- Counts up (stopwatch) or down (reminder interval) on a 1-cycle `tick` strobe, typically the 1 Hz enable.
- Supports preset load, start/stop, expiry detection and optional auto-reload.
- Drives the display digits and raises the reminder pulse for the water-reminder top level.

Parameters:
- STAGES, 2: number of two-digit BCD stages (stage 0 = least significant, e.g. seconds).
- LOW_MOD, 60: modulus of every stage below the top (legal values 00..LOW_MOD-1); range 2..100.
- TOP_MOD, 100: modulus of the top stage (legal values 00..TOP_MOD-1); range 2..100.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low; reset=0 clears all state immediately.
- tick  in  1  count enable strobe, one clk wide.
- load  in  1  copy `preset` into `count` and the reload register.
- preset  in  8*STAGES  BCD preset; byte k = stage k as {tens, ones}.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting.
- down  in  1  1 = count down, 0 = count up; sampled on every tick.
- auto_reload  in  1  down mode only: reload on expiry instead of halting.
- count  out  8*STAGES  current BCD value, same byte layout as `preset`.
- running  out  1  state == RUN.
- expired  out  1  state == EXPIRED.
- done  out  1  1-cycle pulse on down-count expiry.
- wrap  out  1  1-cycle pulse on up-count rollover from the maximum value to zero.

Behaviour:
- Reset (reset=0, async): count=0, reload register=0, state=IDLE, running=0, expired=0, done=0, wrap=0.
- All outputs are registered; count/done/wrap update on the clk edge that samples the tick.
- States: IDLE, RUN, EXPIRED.
- Command priority, per cycle: load > stop > start > tick.
- load, any state:
  - count <= clamp(preset); reload register <= clamp(preset); state -> IDLE.
  - clamp: each digit >9 becomes 9; then each stage value >= its modulus becomes modulus-1, in BCD.
- stop:
  - RUN -> IDLE; count held.
  - EXPIRED -> IDLE; count held (00..00).
  - Ignored in IDLE.
- start, IDLE -> RUN, except down=1 with count==0: ignored.
- start, EXPIRED:
  - count <= reload register; state -> RUN.
  - Ignored if the reload register == 0.
- tick outside RUN: ignored.
- tick in RUN, up mode (down=0):
  - Ripple increment; a stage at modulus-1 rolls to 00 and carries into the next stage.
  - All stages at maximum (e.g. 99:59): count -> 0, wrap=1, stay in RUN. No expiry in up mode.
- tick in RUN, down mode (down=1):
  - Ripple decrement; a stage at 00 borrows and becomes modulus-1 (e.g. 01:00 -> 00:59).
  - Count currently ==1 (would reach zero), with auto_reload=1: count <= reload register, done=1, stay in RUN.
    - Period therefore equals the reload value in ticks.
  - Count currently ==1, with auto_reload=0: count <= 0, done=1, state -> EXPIRED.
  - Count ==0 in RUN, reachable only after a mode change: -> EXPIRED, count held, done=1.
- Mode may change between ticks; the new direction applies to the next tick.
- load and tick in the same cycle: load wins; that tick is lost.
- Reset mid-operation: immediate clear; no done or wrap pulse is emitted.
- Internal count is never an illegal BCD value.

Decomposition:
- Package bcd_timer_pkg:
  - state enum {IDLE, RUN, EXPIRED}.
  - BCD digit typedef (logic [3:0]) and stage typedef (logic [7:0]).
  - Function bcd_clamp(stage, mod).
- Sub-module bcd_stage: one two-digit stage, with parameter MOD.
  - Inputs: en, down, load, load_val.
  - Outputs: value, carry_out (at max going up), borrow_out (at 00 going down).
  - The top module chains STAGES instances via a generate loop and holds the FSM, reload register and pulses.

Test Plan:
- Reset/hold: reset=0 at 22 ns during RUN with count 00:07 -> count=00:00, running=0, done=0 immediately; ticks with start=0 -> count stays 00:00.
- Down count with borrow: load 01:02, start, down=1, 3 ticks -> 01:01, 01:00, 00:59; running=1, done=0.
- Expiry: load 00:02, auto_reload=0, start, 2 ticks -> count 00:00, done high exactly one cycle, expired=1; further ticks -> no change; start -> count 00:02, RUN.
- Auto-reload period: load 00:03, auto_reload=1, 9 ticks -> done pulses on ticks 3, 6 and 9; count 00:03 after each pulse; never shows 00:00.
- Up rollover and clamp: load 99:59 (STAGES=2, TOP_MOD=100), down=0, start, tick -> count 00:00, wrap=1 one cycle, still RUN. Separately, preset 0x7A:0x6C -> count 79:59.
- Priorities: load, stop and tick asserted together in RUN -> count=clamped preset, IDLE. start and stop together in IDLE -> stays IDLE. start in down mode with count 0 -> stays IDLE.
